multi_clock_divider: RTL

//  Parametrised N-channel programmable clock divider for the camera datapath.

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clkdiv_channel.sv | 90 +++++++++
 rtl/multi_clock_divider.sv | 85 ++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int DEF_CNT_W = 10;
  localparam int MIN_DIV   = 2;

  typedef logic [DEF_CNT_W-1:0] div_t;

  typedef struct packed {
    logic [7:0] ch;
    div_t       div;
    div_t       hi;
  } cfg_req_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, single-entry pending config and
// registered outclk / rise strobe.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic [CNT_W-1:0] load_hi,
  output logic             pending,
  output logic             outclk,
  output logic             rise_stb
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HI  = CNT_W'(DEFAULT_DIV / 2);

  logic [CNT_W-1:0] cnt_r, div_r, hi_r, pend_div_r, pend_hi_r;
  logic             pend_r, outclk_r, rise_r;
  logic [CNT_W-1:0] cnt_s, div_s, hi_s, cnt_inc_s;
  logic             wrap_s, apply_s, outclk_s, rise_s;

  // Next state: park when disabled, start a period on wrap/enable/restart, else count.
  always_comb begin
    cnt_inc_s = cnt_r + ONE;
    wrap_s    = (cnt_r == (div_r - ONE));
    apply_s   = 1'b0;
    cnt_s     = cnt_inc_s;
    outclk_s  = 1'b0;
    rise_s    = 1'b0;
    if (!en) begin
      apply_s = pend_r;
      cnt_s   = (pend_r ? pend_div_r : div_r) - ONE;
    end else if (restart || wrap_s) begin
      // A parked channel sits at D-1, so enabling is just an ordinary wrap.
      apply_s  = pend_r;
      cnt_s    = {CNT_W{1'b0}};
      outclk_s = 1'b1;
      rise_s   = 1'b1;
    end else begin
      outclk_s = (cnt_inc_s < hi_r);
    end
    if (apply_s) begin
      div_s = pend_div_r;
      hi_s  = pend_hi_r;
    end else begin
      div_s = div_r;
      hi_s  = hi_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      cnt_r      <= RST_DIV - ONE;
      div_r      <= RST_DIV;
      hi_r       <= RST_HI;
      pend_r     <= 1'b0;
      pend_div_r <= RST_DIV;
      pend_hi_r  <= RST_HI;
      outclk_r   <= 1'b0;
      rise_r     <= 1'b0;
    end else begin
      cnt_r    <= cnt_s;
      div_r    <= div_s;
      hi_r     <= hi_s;
      outclk_r <= outclk_s;
      rise_r   <= rise_s;
      if (load) begin
        pend_r     <= 1'b1;
        pend_div_r <= load_div;
        pend_hi_r  <= load_hi;
      end else if (apply_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign pending  = pend_r;
  assign outclk   = outclk_r;
  assign rise_stb = rise_r;

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider with config handshake and phase restart.
// Define CLKDIV_DUTY_EN to add the cfg_hi port and a per-channel high time.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = DEF_CNT_W,
  parameter int  DEFAULT_DIV = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              in_clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0]  cfg_hi,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] rise_stb
);

  localparam logic [CH_W:0]    NUM_CH_V  = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] MIN_DIV_V = CNT_W'(MIN_DIV);

  logic [NUM_CH-1:0] pending_s, load_s;
  logic [CNT_W-1:0]  hi_s;
  logic              ch_ok_s, req_ok_s, accept_s, cfg_err_r;

  // Request decode: readiness, validity and per-channel load strobes.
  always_comb begin
    ch_ok_s   = ({1'b0, cfg_ch} < NUM_CH_V);
    cfg_ready = 1'b1;
    load_s    = {NUM_CH{1'b0}};
`ifdef CLKDIV_DUTY_EN
    hi_s     = cfg_hi;
    req_ok_s = ch_ok_s && (cfg_div >= MIN_DIV_V) &&
               (cfg_hi != {CNT_W{1'b0}}) && (cfg_hi < cfg_div);
`else
    hi_s     = cfg_div >> 1;
    req_ok_s = ch_ok_s && (cfg_div >= MIN_DIV_V);
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_ready = cfg_ready & ~(pending_s[k] & (cfg_ch == CH_W'(k)));
    end
    accept_s = cfg_valid & cfg_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      load_s[k] = accept_s & req_ok_s & (cfg_ch == CH_W'(k));
    end
  end

  // Rejected requests are consumed and reported one cycle later.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= accept_s & ~req_ok_s;
    end
  end

  assign cfg_err = cfg_err_r;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clkdiv_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .in_clk  (in_clk),
      .reset   (reset),
      .en      (ch_en[k]),
      .restart (sync_restart),
      .load    (load_s[k]),
      .load_div(cfg_div),
      .load_hi (hi_s),
      .pending (pending_s[k]),
      .outclk  (outclk[k]),
      .rise_stb(rise_stb[k])
    );
  end

endmodule
